// File: rtl/spi_frame_master.sv
// SPI mode-0 master: one frame of NBYTES full-duplex bytes, MSB first, framed by SSEL.
// Transmit bytes are fetched per index through tx_load/byte_idx; received bytes leave with their index.
module spi_frame_master #(
    parameter int NBYTES = 20,
    parameter int DIV    = 4,
    parameter int CSGAP  = 4
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [4:0] byte_idx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       SCK,
    output logic       MOSI,
    output logic       SSEL,
    input  logic       MISO
);

    localparam int CMAX = (DIV > CSGAP) ? DIV : CSGAP;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] DIV_PRE   = CW'(DIV - 2);
    localparam logic [CW-1:0] GAP_LAST  = CW'(CSGAP - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [4:0]    LAST_BYTE = 5'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic [2:0]      bit_reg;
    logic [4:0]      idx_reg;
    logic [7:0]      tx_shift_reg;
    logic [7:0]      rx_shift_reg;
    logic [7:0]      rx_data_reg;
    logic            mosi_reg;
    logic            sck_reg;
    logic            ssel_reg;
    logic            rx_valid_reg;
    logic            aborted_reg;

    logic            in_frame;
    logic            abort_hit;
    logic            high_end;
    logic            last_bit;
    logic            last_byte;
    logic            rx_deliver;

    assign in_frame  = (state_reg == S_LOAD) || (state_reg == S_SETUP) ||
                       (state_reg == S_HIGH) || (state_reg == S_LOW);
    assign abort_hit = abort && in_frame;
    assign high_end  = (state_reg == S_HIGH) && (cnt_reg == DIV_LAST);
    assign last_bit  = (bit_reg == 3'd7);
    assign last_byte = (idx_reg == LAST_BYTE);

    // The byte is assembled one cycle before the HIGH phase ends, so rx_valid lands in the
    // final HIGH cycle while byte_idx still names this byte. An abort in that cycle still delivers.
    assign rx_deliver = (state_reg == S_HIGH) && (cnt_reg == DIV_PRE) && last_bit && !abort;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (idx_reg == 5'd0) begin
                    state_next = S_SETUP;
                    cnt_next   = '0;
                end else begin
                    // an inter-byte LOAD is the first cycle of that LOW phase
                    state_next = S_LOW;
                    cnt_next   = CNT_ONE;
                end
            end
            S_SETUP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                end
            end
            S_HIGH: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next = '0;
                    if (last_bit && last_byte) begin
                        state_next = S_HOLD;
                    end else if (last_bit) begin
                        state_next = S_LOAD;
                    end else begin
                        state_next = S_LOW;
                    end
                end
            end
            S_LOW: begin
                if (cnt_reg == DIV_LAST) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = S_GAP;
                    cnt_next   = '0;
                end
            end
            S_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
        if (abort_hit) begin
            state_next = S_HOLD;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            idx_reg      <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            mosi_reg     <= 1'b0;
            sck_reg      <= 1'b0;
            ssel_reg     <= 1'b1;
            rx_valid_reg <= 1'b0;
            aborted_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            // pins are registered from the next state so SCK/SSEL never glitch
            sck_reg      <= (state_next == S_HIGH);
            ssel_reg     <= (state_next == S_IDLE) || (state_next == S_GAP);
            rx_valid_reg <= rx_deliver;

            if (rx_deliver) begin
                rx_data_reg <= rx_shift_reg;
            end

            if ((state_reg == S_IDLE) && start) begin
                idx_reg     <= '0;
                bit_reg     <= '0;
                aborted_reg <= 1'b0;
            end

            if (abort_hit) begin
                aborted_reg <= 1'b1;
            end

            if (state_reg == S_LOAD) begin
                tx_shift_reg <= tx_data;
                mosi_reg     <= tx_data[7];
            end

            if ((state_reg == S_HIGH) && (cnt_reg == '0)) begin
                rx_shift_reg <= {rx_shift_reg[6:0], MISO};
            end

            if (high_end && !abort_hit) begin
                bit_reg <= bit_reg + 3'd1;
                if (last_bit) begin
                    if (!last_byte) begin
                        idx_reg <= idx_reg + 5'd1;
                    end
                end else begin
                    tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                    mosi_reg     <= tx_shift_reg[6];
                end
            end
        end
    end

    assign tx_load  = (state_reg == S_LOAD);
    assign byte_idx = idx_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign busy     = (state_reg != S_IDLE);
    assign done     = (state_reg == S_GAP) && (cnt_reg == GAP_LAST);
    assign aborted  = aborted_reg;
    assign SCK      = sck_reg;
    // bit 7 of a freshly loaded byte goes straight out during LOAD
    assign MOSI     = (state_reg == S_LOAD) ? tx_data[7] : mosi_reg;
    assign SSEL     = ssel_reg;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: random tx/slave bytes, a pin-level observer acting as the slave,
// and frame-level expectations derived from byte counts and the frame timing formula.
module tb_spi_frame_master;

    localparam int NB      = 3;
    localparam int DV      = 4;
    localparam int CG      = 5;
    localparam int EXP_LEN = 1 + 2 * CG + (16 * NB - 1) * DV;
    localparam int TMO     = 4 * EXP_LEN;

    logic       clk = 1'b0;
    logic       nRESET;
    logic       start;
    logic       abort;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [4:0] byte_idx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       SCK;
    logic       MOSI;
    logic       SSEL;
    logic       MISO = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_mem [NB];
    logic [7:0] sl_mem [NB];

    // observer state for the current frame
    int         cyc = 0;
    int         ssel_low;
    int         ssel_fall_cyc;
    int         first_rise_cyc;
    int         rise_cnt;
    int         done_cnt;
    int         viol;
    logic [7:0] rx_q[$];
    int         rxi_q[$];
    int         load_q[$];
    logic       mosi_q[$];
    logic       prev_ssel = 1'b1;
    logic       prev_sck  = 1'b0;
    logic       prev_mosi = 1'b0;

    spi_frame_master #(
        .NBYTES(NB),
        .DIV(DV),
        .CSGAP(CG)
    ) dut (
        .clk(clk),
        .nRESET(nRESET),
        .start(start),
        .abort(abort),
        .tx_data(tx_data),
        .tx_load(tx_load),
        .byte_idx(byte_idx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .SCK(SCK),
        .MOSI(MOSI),
        .SSEL(SSEL),
        .MISO(MISO)
    );

    always #5 clk = ~clk;

    // Source mux returns the complement outside tx_load so a capture at the wrong time shows up.
    always_comb begin
        tx_data = 8'h00;
        if (int'(byte_idx) < NB) begin
            tx_data = tx_load ? tx_mem[byte_idx] : ~tx_mem[byte_idx];
        end
    end

    function automatic logic slave_bit(input int n);
        if (n >= 8 * NB) return 1'b0;
        return sl_mem[n / 8][3'(7 - (n % 8))];
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!SSEL) ssel_low++;
        if (!SSEL && prev_ssel) ssel_fall_cyc = cyc;
        if (SCK && !prev_sck) begin
            rise_cnt++;
            if (rise_cnt == 1) first_rise_cyc = cyc;
            mosi_q.push_back(MOSI);
        end
        if (SCK && (MOSI !== prev_mosi)) viol++;
        if (tx_load) load_q.push_back(int'(byte_idx));
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            rxi_q.push_back(int'(byte_idx));
        end
        if (done) done_cnt++;
        // slave shifts its next bit out while SCK is low
        if (!SCK) MISO = slave_bit(rise_cnt);
        prev_ssel = SSEL;
        prev_sck  = SCK;
        prev_mosi = MOSI;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        ssel_low       = 0;
        ssel_fall_cyc  = -1;
        first_rise_cyc = -1;
        rise_cnt       = 0;
        done_cnt       = 0;
        viol           = 0;
        rx_q.delete();
        rxi_q.delete();
        load_q.delete();
        mosi_q.delete();
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the LOAD cycle.
    task automatic start_frame(input bit with_abort);
        for (int i = 0; i < NB; i++) begin
            tx_mem[i] = 8'($urandom);
            sl_mem[i] = 8'($urandom);
        end
        mon_clear();
        start = 1'b1;
        abort = with_abort;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("load_cycle_tx_load", 32'(tx_load), 32'd1);
        chk("start_clears_aborted", 32'(aborted), 32'd0);
    endtask

    task automatic wait_done(input bit noise);
        int  n = 0;
        bit  gap_poked = 1'b0;
        while (!done && n < TMO) begin
            if (noise && busy && ((SSEL && !gap_poked) || $urandom_range(0, 9) == 0)) begin
                start = 1'b1;
                if (SSEL) gap_poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_in_done_cycle", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_full_frame();
        chk("ssel_low_len", 32'(ssel_low), 32'(EXP_LEN));
        chk("first_rise_delay", 32'(first_rise_cyc - ssel_fall_cyc), 32'(CG + 1));
        chk("sck_rises", 32'(rise_cnt), 32'(8 * NB));
        chk("mosi_stable_sck_high", 32'(viol), 32'd0);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("aborted_clear", 32'(aborted), 32'd0);
        chk("tx_load_count", 32'(load_q.size()), 32'(NB));
        chk("rx_valid_count", 32'(rx_q.size()), 32'(NB));
        chk("mosi_bit_count", 32'(mosi_q.size()), 32'(8 * NB));
        for (int i = 0; i < NB && i < load_q.size(); i++)
            chk($sformatf("tx_load_idx%0d", i), 32'(load_q[i]), 32'(i));
        for (int i = 0; i < NB && i < rx_q.size(); i++) begin
            chk($sformatf("rx_data%0d", i), 32'(rx_q[i]), 32'(sl_mem[i]));
            chk($sformatf("rx_idx%0d", i), 32'(rxi_q[i]), 32'(i));
        end
        for (int b = 0; b < 8 * NB && b < mosi_q.size(); b++)
            chk($sformatf("mosi_bit%0d", b), 32'(mosi_q[b]), 32'(tx_mem[b / 8][3'(7 - (b % 8))]));
    endtask

    // mode 0: abort in the first SCK-high cycle of rise e; mode 1: abort in the first low cycle after rise e
    task automatic abort_frame(input int mode, input int e);
        int   k = 0;
        int   n = 0;
        int   low_after = 0;
        int   deliv;
        logic last_sck;
        bit   hit = 1'b0;
        start_frame(1'b0);
        last_sck = SCK;
        while (!hit && n < TMO) begin
            @(posedge clk); #1;
            n++;
            if (SCK && !last_sck) k++;
            if ((mode == 0 && SCK && !last_sck && k == e) ||
                (mode == 1 && !SCK && last_sck && k == e)) hit = 1'b1;
            last_sck = SCK;
        end
        chk("abort_point_reached", 32'(hit), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_sck_low", 32'(SCK), 32'd0);
        chk("abort_aborted_set", 32'(aborted), 32'd1);
        while (!SSEL && low_after < TMO) begin
            low_after++;
            @(posedge clk); #1;
        end
        chk("abort_ssel_hold", 32'(low_after), 32'(CG));
        wait_done(1'b0);
        deliv = (mode == 0) ? (e - 1) / 8 : e / 8;
        chk("abort_done_pulses", 32'(done_cnt), 32'd1);
        chk("abort_aborted_kept", 32'(aborted), 32'd1);
        chk("abort_rx_count", 32'(rx_q.size()), 32'(deliv));
        for (int i = 0; i < deliv && i < rx_q.size(); i++) begin
            chk($sformatf("abort_rx_data%0d", i), 32'(rx_q[i]), 32'(sl_mem[i]));
            chk($sformatf("abort_rx_idx%0d", i), 32'(rxi_q[i]), 32'(i));
        end
        $display("abort frame mode=%0d edge=%0d delivered=%0d", mode, e, rx_q.size());
    endtask

    initial begin
        int mode;
        int e;
        int wait_cyc;
        nRESET = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        mon_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ssel", 32'(SSEL), 32'd1);
        chk("rst_sck", 32'(SCK), 32'd0);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tx_load", 32'(tx_load), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_byte_idx", 32'(byte_idx), 32'd0);
        nRESET = 1'b1;
        @(posedge clk); #1;

        // plain frame, then start together with abort in IDLE (start wins)
        start_frame(1'b0);
        wait_done(1'b0);
        check_full_frame();
        $display("frame plain tx0=%02h rx0=%02h", tx_mem[0], rx_q.size() > 0 ? rx_q[0] : 8'h00);
        repeat (2) @(posedge clk);
        #1;
        start_frame(1'b1);
        wait_done(1'b0);
        check_full_frame();
        $display("frame start+abort tx0=%02h", tx_mem[0]);

        // stray starts while busy and during GAP; second frame starts right after done
        for (int f = 0; f < 2; f++) begin
            start_frame(1'b0);
            wait_done(1'b1);
            check_full_frame();
            $display("frame noisy %0d done", f);
        end
        start_frame(1'b0);
        wait_done(1'b0);
        check_full_frame();
        $display("frame back-to-back done");
        repeat (2) @(posedge clk);
        #1;
        chk("no_queued_start", 32'(busy), 32'd0);

        for (int a = 0; a < 5; a++) begin
            mode = (a < 2) ? a : int'($urandom_range(0, 1));
            e = (mode == 0) ? int'($urandom_range(1, 8 * NB)) : int'($urandom_range(1, 8 * NB - 1));
            if (a == 0) e = 12;
            abort_frame(mode, e);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        start_frame(1'b0);
        wait_done(1'b0);
        check_full_frame();
        $display("frame after aborts done");

        // reset in the middle of a frame
        @(posedge clk); #1;
        start_frame(1'b0);
        wait_cyc = int'($urandom_range(20, 150));
        repeat (wait_cyc) @(posedge clk);
        #1;
        nRESET = 1'b0;
        @(posedge clk); #1;
        mon_clear();
        chk("midrst_ssel", 32'(SSEL), 32'd1);
        chk("midrst_sck", 32'(SCK), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_byte_idx", 32'(byte_idx), 32'd0);
        nRESET = 1'b1;
        repeat (3 * CG + 5) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        chk("midrst_no_rx", 32'(rx_q.size()), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);
        $display("mid-frame reset after %0d cycles", wait_cyc);
        start_frame(1'b0);
        wait_done(1'b0);
        check_full_frame();
        $display("frame after reset done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
SPI mode-0 master that drives one complete stepper-board transfer frame: SSEL low, NBYTES bytes full-duplex MSB-first, SSEL high. It is the host-side end of the pluto SPI link, used on bench/host FPGAs and in co-simulation to drive the stepper firmware's slave port. Transmit bytes are pulled from a byte-indexed source (register file mux). Received bytes are presented with their index.

Parameters:
NBYTES, 20, bytes per frame (1..31).
DIV, 4, SCK half-period in clk cycles; must be >= 4 so a same-clock slave with a 3-stage synchroniser can follow.
CSGAP, 4, clk cycles of SSEL setup before the first SCK edge, hold after the last edge, and minimum SSEL-high gap (>= 1).

Ports:
clk  input  1  system clock
nRESET  input  1  synchronous active-low reset
start  input  1  begin a frame; honoured only in IDLE
abort  input  1  terminate the current frame early
tx_data  input  8  byte to send; must be valid in the cycle tx_load=1 for byte_idx
tx_load  output  1  one-cycle pulse; tx_data captured this cycle
byte_idx  output  5  index of the byte being loaded or received
rx_data  output  8  last received byte
rx_valid  output  1  one-cycle pulse; rx_data/byte_idx valid
busy  output  1  high from start acceptance until the done cycle
done  output  1  one-cycle pulse at end of frame
aborted  output  1  set when a frame ends by abort; cleared on next start
SCK  output  1  SPI clock, idle low
MOSI  output  1  SPI data out
SSEL  output  1  chip select, active low
MISO  input  1  SPI data in; sampled directly, no synchroniser

Behaviour:
- Reset (nRESET=0 at a clk edge), from any state including mid-frame: state IDLE, SSEL=1, SCK=0, MOSI=0, busy=0, done=0, tx_load=0, rx_valid=0, aborted=0, rx_data=0, byte_idx=0. No done pulse is produced for a frame killed by reset.
- States: IDLE, LOAD, SETUP, HIGH, LOW, HOLD, GAP.
- IDLE: on start, go to LOAD. busy=1 from that next cycle.
- LOAD (1 cycle): SSEL=0, SCK=0, tx_load=1.
  - tx_data is captured into the tx shifter and bit7 driven on MOSI.
  - First LOAD of a frame goes to SETUP with byte_idx=0.
  - Later LOADs are the first cycle of a LOW phase, so the LOW counter continues.
- SETUP: CSGAP cycles, then HIGH.
- HIGH: SCK=1 for DIV cycles.
  - In the first HIGH cycle (rising edge), MISO is shifted into the rx shifter LSB.
  - At the end of HIGH:
    - If bit 8 of the byte is done: rx_data <= assembled byte and rx_valid pulses one cycle, with byte_idx still that byte's index.
    - Then, if the last byte is done, go to HOLD.
    - Else, if bit 8 is done, byte_idx+1 and go to LOAD.
    - Else go to LOW, with MOSI shifted to the next bit in the first LOW cycle (falling edge).
- LOW: SCK=0 for DIV cycles, then HIGH.
- HOLD: SCK=0, SSEL=0 for CSGAP cycles; then SSEL=1 and go to GAP.
- GAP: SSEL=1 for CSGAP cycles. In the last GAP cycle done=1, busy goes 0 the following cycle, then IDLE.
- A start during GAP or earlier is ignored, not queued.
- SSEL-low duration is exactly 1 + 2*CSGAP + (16*NBYTES-1)*DIV cycles. For the defaults this is 1285.
- abort, in LOAD/SETUP/HIGH/LOW:
  - Next cycle: SCK=0, state HOLD, aborted=1.
  - No rx_valid for a partial byte; a byte completing in the abort cycle is still delivered.
  - abort in HOLD/GAP/IDLE has no effect.
- start and abort together in IDLE: start wins, abort ignored.
- byte_idx wraps never; NBYTES<=31 guarantees this.
- MOSI holds its last value after the final bit until reset or next LOAD.

Test Plan:
1. Reset then start with NBYTES=2, DIV=4, CSGAP=4, tx_data=0xA5 (idx0) / 0x3C (idx1), MISO looped to MOSI: SSEL low for 1+8+31*4=133 cycles; 16 SCK rising edges; rx_valid twice with 0xA5 (idx0) and 0x3C (idx1); done once; busy falls the cycle after done.
2. Default parameters, MISO tied 1: SSEL low 1285 cycles; 20 tx_load pulses with byte_idx 0..19; 20 rx_valid pulses each 0xFF.
3. Edge timing: MOSI only changes in LOAD or the first LOW cycle, never while SCK=1; first rising edge exactly CSGAP+1 cycles after SSEL falls.
4. Abort after the 12th rising edge (byte 1, bit 4): SCK low next cycle; rx_valid only for idx0; SSEL high after CSGAP; done pulses; aborted=1; next start clears aborted.
5. start pulsed while busy and during GAP: ignored, frame length unchanged; start the cycle after done begins a new frame.
6. nRESET low mid-byte: next cycle SSEL=1, SCK=0, busy=0; no done or rx_valid pulse; a fresh start afterwards yields a correct frame.
